// File: rtl/axis_stall_detector.sv
`default_nettype none
// ============================================================================
// Module      : axis_stall_detector
// Description : Watches the tvalid/tready pairs of a DUT's AXI-Stream ports
//               and raises a per-channel block flag when the DUT has gone
//               STALL_THRESH consecutive cycles without any stream transfer
//               while at least one channel waits on its peer. An input channel
//               is stalled when it is ready but starved. An output channel is
//               stalled when it is valid but backpressured. The resulting flag
//               vector feeds the cosim deadlock monitor.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clock              in   1        clock
//   reset              in   1        synchronous, active-high reset
//   enable_i           in   1        1 = detection active
//   ch_tvalid_i        in   NUM_CH   tvalid of each channel
//   ch_tready_i        in   NUM_CH   tready of each channel
//   axis_block_sigs_o  out  NUM_CH   registered per-channel block flags
//   any_block_o        out  1        registered OR of the block flags
//   first_block_idx_o  out  IDX_W    lowest flagged channel at BLOCKED entry
//   stall_count_o      out  CNT_W    consecutive stall cycles, saturating
// ============================================================================
module axis_stall_detector #(
    parameter int                NUM_CH       = 2,
    parameter logic [NUM_CH-1:0] DIR_MASK     = NUM_CH'(2'b01),
    parameter int                STALL_THRESH = 1024,
    parameter int                CNT_W        = 16,
    localparam int               IDX_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              enable_i,
    input  logic [NUM_CH-1:0] ch_tvalid_i,
    input  logic [NUM_CH-1:0] ch_tready_i,
    output logic [NUM_CH-1:0] axis_block_sigs_o,
    output logic              any_block_o,
    output logic [IDX_W-1:0]  first_block_idx_o,
    output logic [CNT_W-1:0]  stall_count_o
);

    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] THRESH_M1 = CNT_W'(STALL_THRESH - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_RUN     = 2'd1,
        S_COUNT   = 2'd2,
        S_BLOCKED = 2'd3
    } state_t;

    state_t            state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [NUM_CH-1:0] sigs_q;
    logic              any_q;
    logic [IDX_W-1:0]  idx_q;

    logic [NUM_CH-1:0] cand;
    logic              progress;
    logic              stall;
    logic [IDX_W-1:0]  low_idx;
    logic [CNT_W-1:0]  cnt_inc_d;

    // A channel is a block candidate when it waits on its peer: inputs are
    // ready but starved, outputs are valid but backpressured.
    always_comb begin
        cand = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            cand[i] = DIR_MASK[i] ? (ch_tready_i[i] & ~ch_tvalid_i[i])
                                  : (ch_tvalid_i[i] & ~ch_tready_i[i]);
        end
    end

    // A transfer on any channel counts as forward progress for all of them.
    assign progress = |(ch_tvalid_i & ch_tready_i);
    assign stall    = (|cand) & ~progress;

    // Lowest set candidate bit; scanning downward lets the lowest win.
    always_comb begin
        low_idx = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (cand[i]) begin
                low_idx = IDX_W'(i);
            end
        end
    end

    assign cnt_inc_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);

    always_ff @(posedge clock) begin
        if (reset || !enable_i) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            sigs_q  <= '0;
            any_q   <= 1'b0;
            idx_q   <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    state_q <= S_RUN;
                end
                S_RUN: begin
                    if (stall) begin
                        state_q <= S_COUNT;
                        cnt_q   <= CNT_W'(1);
                    end else begin
                        cnt_q   <= '0;
                    end
                end
                S_COUNT: begin
                    if (!stall) begin
                        state_q <= S_RUN;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_inc_d;
                        // Count reaches the threshold on this edge: flags
                        // become visible exactly STALL_THRESH cycles after
                        // the first stalled cycle.
                        if (cnt_q == THRESH_M1) begin
                            state_q <= S_BLOCKED;
                            sigs_q  <= cand;
                            any_q   <= |cand;
                            idx_q   <= low_idx;
                        end
                    end
                end
                S_BLOCKED: begin
                    if (!stall) begin
                        state_q <= S_RUN;
                        cnt_q   <= '0;
                        sigs_q  <= '0;
                        any_q   <= 1'b0;
                        idx_q   <= '0;
                    end else begin
                        // Flag set tracks the live candidates; the entry
                        // index is held until the block clears.
                        sigs_q <= cand;
                        any_q  <= |cand;
                        cnt_q  <= cnt_inc_d;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign axis_block_sigs_o = sigs_q;
    assign any_block_o       = any_q;
    assign first_block_idx_o = idx_q;
    assign stall_count_o     = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_axis_stall_detector.sv
`default_nettype none
// ============================================================================
// Module      : tb_axis_stall_detector
// Description : Self-checking bench for axis_stall_detector. Two instances
//               share stimulus: one with a 16-bit counter, one with a 4-bit
//               counter to reach saturation. Both are compared every cycle
//               against a run-length model of the stall rules.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axis_stall_detector;

    localparam int            NUM_CH = 2;
    localparam int            THRESH = 8;
    localparam logic [1:0]    DMASK  = 2'b01;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       enable = 1'b0;
    logic [1:0] ch_tvalid = 2'b00;
    logic [1:0] ch_tready = 2'b00;

    logic [1:0]  sigs_a, sigs_b;
    logic        any_a, any_b;
    logic        idx_a, idx_b;
    logic [15:0] cnt_a;
    logic [3:0]  cnt_b;

    int errors = 0;
    int checks = 0;

    // Reference model state
    bit         m_active = 1'b0;
    int         m_run    = 0;
    logic [1:0] m_sigs   = 2'b00;
    logic       m_idx    = 1'b0;

    always #5 clock = ~clock;

    axis_stall_detector #(
        .NUM_CH(NUM_CH), .DIR_MASK(DMASK), .STALL_THRESH(THRESH), .CNT_W(16)
    ) dut_a (
        .clock(clock), .reset(reset), .enable_i(enable),
        .ch_tvalid_i(ch_tvalid), .ch_tready_i(ch_tready),
        .axis_block_sigs_o(sigs_a), .any_block_o(any_a),
        .first_block_idx_o(idx_a), .stall_count_o(cnt_a)
    );

    axis_stall_detector #(
        .NUM_CH(NUM_CH), .DIR_MASK(DMASK), .STALL_THRESH(THRESH), .CNT_W(4)
    ) dut_b (
        .clock(clock), .reset(reset), .enable_i(enable),
        .ch_tvalid_i(ch_tvalid), .ch_tready_i(ch_tready),
        .axis_block_sigs_o(sigs_b), .any_block_o(any_b),
        .first_block_idx_o(idx_b), .stall_count_o(cnt_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: apply inputs, advance the model by the stall rules, then
    // compare both instances just after the edge.
    task automatic step(input logic rst_v, input logic en_v,
                        input logic [1:0] tv, input logic [1:0] tr);
        logic [1:0] cand;
        logic       stl;
        reset     = rst_v;
        enable    = en_v;
        ch_tvalid = tv;
        ch_tready = tr;
        @(posedge clock);
        for (int i = 0; i < 2; i++)
            cand[i] = DMASK[i] ? (tr[i] & ~tv[i]) : (tv[i] & ~tr[i]);
        stl = (|cand) && !(|(tv & tr));
        if (rst_v || !en_v) begin
            m_active = 1'b0;
            m_run    = 0;
        end else if (!m_active) begin
            m_active = 1'b1;
            m_run    = 0;
        end else if (stl) begin
            m_run++;
        end else begin
            m_run = 0;
        end
        if (m_run >= THRESH) begin
            m_sigs = cand;
            if (m_run == THRESH) m_idx = cand[0] ? 1'b0 : 1'b1;
        end else begin
            m_sigs = 2'b00;
            m_idx  = 1'b0;
        end
        #1;
        chk("sigs_a", 32'(sigs_a), 32'(m_sigs));
        chk("any_a",  32'(any_a),  32'(|m_sigs));
        chk("idx_a",  32'(idx_a),  32'(m_idx));
        chk("cnt_a",  32'(cnt_a),  32'((m_run > 65535) ? 65535 : m_run));
        chk("sigs_b", 32'(sigs_b), 32'(m_sigs));
        chk("cnt_b",  32'(cnt_b),  32'((m_run > 15) ? 15 : m_run));
    endtask

    task automatic hold(input int n, input logic [1:0] tv, input logic [1:0] tr);
        for (int k = 0; k < n; k++) step(1'b0, 1'b1, tv, tr);
    endtask

    initial begin
        logic [1:0] pv [4];
        logic [1:0] pr [4];
        int         len, kind, p;
        logic [1:0] tv, tr;

        // Reset state
        repeat (3) step(1'b1, 1'b0, 2'b00, 2'b00);
        chk("reset_sigs", 32'(sigs_a), 32'd0);
        chk("reset_cnt",  32'(cnt_a),  32'd0);

        // 1: starved input ch0, flag only at +THRESH
        step(1'b0, 1'b1, 2'b00, 2'b01);          // IDLE -> RUN
        hold(THRESH - 1, 2'b00, 2'b01);
        chk("t1_pre_sigs", 32'(sigs_a), 32'd0);
        hold(1, 2'b00, 2'b01);
        chk("t1_sigs", 32'(sigs_a), 32'h1);
        chk("t1_any",  32'(any_a),  32'h1);
        chk("t1_idx",  32'(idx_a),  32'h0);

        // 2: backpressured output for THRESH-1 cycles, then ch0 transfer
        hold(1, 2'b01, 2'b01);
        hold(THRESH - 1, 2'b10, 2'b00);
        hold(1, 2'b11, 2'b01);
        chk("t2_sigs", 32'(sigs_a), 32'd0);
        chk("t2_cnt",  32'(cnt_a),  32'd0);

        // 3: both stalled, ch1 released while blocked, then full re-stall
        hold(THRESH, 2'b10, 2'b01);
        chk("t3_both", 32'(sigs_a), 32'h3);
        hold(1, 2'b10, 2'b11);
        chk("t3_release", 32'(sigs_a), 32'd0);
        hold(THRESH - 1, 2'b10, 2'b01);
        chk("t3_restall_pre", 32'(sigs_a), 32'd0);
        hold(1, 2'b10, 2'b01);
        chk("t3_restall", 32'(sigs_a), 32'h3);

        // 4: ch0 drops tready while blocked
        hold(1, 2'b10, 2'b00);
        chk("t4_sigs", 32'(sigs_a), 32'h2);
        chk("t4_idx",  32'(idx_a),  32'h0);

        // 5: reset, then enable low, during BLOCKED
        step(1'b1, 1'b1, 2'b10, 2'b00);
        chk("t5_rst_any", 32'(any_a), 32'd0);
        hold(1 + THRESH, 2'b10, 2'b00);
        chk("t5_reflag", 32'(sigs_a), 32'h2);
        chk("t5_idx",    32'(idx_a),  32'h1);
        step(1'b0, 1'b0, 2'b10, 2'b00);
        chk("t5_dis_cnt", 32'(cnt_a), 32'd0);
        hold(1 + THRESH, 2'b10, 2'b01);

        // 6: long stall saturates the narrow counter
        hold(40, 2'b10, 2'b01);
        chk("t6_cnt_sat", 32'(cnt_b), 32'd15);
        chk("t6_sigs",    32'(sigs_b), 32'h3);

        // Random segments, biased toward held stall patterns
        pv[0] = 2'b00; pr[0] = 2'b01;
        pv[1] = 2'b10; pr[1] = 2'b00;
        pv[2] = 2'b10; pr[2] = 2'b01;
        pv[3] = 2'b00; pr[3] = 2'b00;
        for (int seg = 0; seg < 80; seg++) begin
            len  = $urandom_range(1, 14);
            kind = $urandom_range(0, 19);
            if (kind == 0) begin
                step(1'b1, 1'b1, 2'($urandom), 2'($urandom));
            end else if (kind == 1) begin
                step(1'b0, 1'b0, 2'($urandom), 2'($urandom));
            end else begin
                if (kind < 12) begin
                    p  = $urandom_range(0, 3);
                    tv = pv[p];
                    tr = pr[p];
                end else begin
                    tv = 2'($urandom);
                    tr = 2'($urandom);
                end
                for (int k = 0; k < len; k++) begin
                    if ($urandom_range(0, 15) == 0) tr[0] = ~tr[0];
                    step(1'b0, 1'b1, tv, tr);
                end
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
